// File: rtl/apb_bus_arb.sv
// Round-robin arbiter and APB master sequencer letting NUM_REQ requesters share one APB bus.
// Each granted request runs SETUP -> ACCESS (wait states, pslverr, timeout abort) -> RESP.
`timescale 1ns/1ps
module apb_bus_arb #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_gnt,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic                             psel,
  output logic                             penable,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [DATA_WIDTH-1:0]            prdata,
  input  logic                             pready,
  input  logic                             pslverr
);

  localparam int         IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TO_LAST = 8'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       last_idx;
  logic [7:0]             to_cnt;

  logic [IDX_W-1:0]       win_idx;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic                   win_write;
  logic [DATA_WIDTH-1:0]  win_wdata;
  logic [NUM_REQ-1:0]     win_onehot;
  logic                   to_hit;

  // First requester with valid set, searching upward from the one after the last grant.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!found && vld[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    win_idx    = rr_pick(req_valid, last_idx);
    win_addr   = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    win_write  = req_write[win_idx];
    win_wdata  = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
    win_onehot = NUM_REQ'(1) << win_idx;
    to_hit     = TO_EN && (to_cnt == TO_LAST);
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state       <= IDLE;
      last_idx    <= IDX_W'(NUM_REQ - 1);
      to_cnt      <= '0;
      req_gnt     <= '0;
      req_done    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            paddr    <= win_addr;
            pwrite   <= win_write;
            pwdata   <= win_wdata;
            req_gnt  <= win_onehot;
            last_idx <= win_idx;
            psel     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            req_done    <= req_gnt;
            to_cnt      <= '0;
            state       <= RESP;
          end else if (to_hit) begin
            // Hung slave: abort and report an error without read data.
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            req_done    <= req_gnt;
            to_cnt      <= '0;
            state       <= RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        RESP: begin
          req_done <= '0;
          req_gnt  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
